arbitro_memoria_datos: RTL

//  Shares the single-port data memory (memoria_datos) between two requesters:

---
 rtl/arbitro_memoria_datos.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/arbitro_memoria_datos.sv
// arbitro_memoria_datos: shares the single-port data memory between pipeline port P and loader/debug port D.
// Build macro ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed priority with anti-starvation.
module arbitro_memoria_datos #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MAX_ESPERA = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_p,
   input  logic              we_p,
   input  logic [ADDR_W-1:0] addr_p,
   input  logic [DATA_W-1:0] wdata_p,
   output logic              gnt_p,
   output logic              rvalid_p,
   output logic [DATA_W-1:0] rdata_p,
   input  logic              req_d,
   input  logic              we_d,
   input  logic [ADDR_W-1:0] addr_d,
   input  logic [DATA_W-1:0] wdata_d,
   output logic              gnt_d,
   output logic              rvalid_d,
   output logic [DATA_W-1:0] rdata_d,
   output logic              EscrMem,
   output logic              LeerMem,
   output logic [ADDR_W-1:0] Direc,
   output logic [DATA_W-1:0] Datain,
   input  logic [DATA_W-1:0] Dataout,
   output logic              ocupado
);

   typedef enum logic [0:0] {
      OCIOSO = 1'b0,
      ACCESO = 1'b1
   } estado_t;

   estado_t             estado_r;
   estado_t             estado_s;
   logic                gana_p_s;
   logic                gana_d_s;
   logic                escr_r;
   logic                leer_r;
   logic [ADDR_W-1:0]   direc_r;
   logic [DATA_W-1:0]   datain_r;
   logic                puerto_d_r;
   logic                rvalid_p_r;
   logic                rvalid_d_r;
   logic [DATA_W-1:0]   rdata_p_r;
   logic [DATA_W-1:0]   rdata_d_r;

`ifdef ARB_ROUND_ROBIN_EN
   logic                ultimo_d_r;
`else
   localparam int              EW         = $clog2(MAX_ESPERA + 1);
   localparam logic [EW-1:0]   ESPERA_MAX = EW'(MAX_ESPERA);
   logic [EW-1:0]              espera_r;
`endif

   // Arbitration: only in OCIOSO and never while reset is asserted
   always_comb begin
      gana_p_s = 1'b0;
      gana_d_s = 1'b0;
      if ((estado_r == OCIOSO) && !reset) begin
         if (req_p && req_d) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (ultimo_d_r) begin
               gana_p_s = 1'b1;
            end else begin
               gana_d_s = 1'b1;
            end
`else
            if (espera_r == ESPERA_MAX) begin
               gana_d_s = 1'b1;
            end else begin
               gana_p_s = 1'b1;
            end
`endif
         end else if (req_p) begin
            gana_p_s = 1'b1;
         end else if (req_d) begin
            gana_d_s = 1'b1;
         end else begin
            gana_p_s = 1'b0;
            gana_d_s = 1'b0;
         end
      end else begin
         gana_p_s = 1'b0;
         gana_d_s = 1'b0;
      end
   end

   // Next-state logic: every grant costs exactly one ACCESO cycle
   always_comb begin
      estado_s = estado_r;
      case (estado_r)
         OCIOSO: begin
            if (gana_p_s || gana_d_s) begin
               estado_s = ACCESO;
            end else begin
               estado_s = OCIOSO;
            end
         end
         ACCESO:  estado_s = OCIOSO;
         default: estado_s = OCIOSO;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         estado_r <= OCIOSO;
      end else begin
         estado_r <= estado_s;
      end
   end

   // Memory bus registers: loaded with the winner's request, cleared after the access
   always_ff @(posedge clk) begin
      if (reset) begin
         escr_r     <= 1'b0;
         leer_r     <= 1'b0;
         direc_r    <= {ADDR_W{1'b0}};
         datain_r   <= {DATA_W{1'b0}};
         puerto_d_r <= 1'b0;
      end else if (gana_d_s) begin
         escr_r     <= we_d;
         leer_r     <= ~we_d;
         direc_r    <= addr_d;
         datain_r   <= wdata_d;
         puerto_d_r <= 1'b1;
      end else if (gana_p_s) begin
         escr_r     <= we_p;
         leer_r     <= ~we_p;
         direc_r    <= addr_p;
         datain_r   <= wdata_p;
         puerto_d_r <= 1'b0;
      end else begin
         escr_r     <= 1'b0;
         leer_r     <= 1'b0;
         direc_r    <= {ADDR_W{1'b0}};
         datain_r   <= {DATA_W{1'b0}};
         puerto_d_r <= puerto_d_r;
      end
   end

   // Read return: capture Dataout at the end of ACCESO for the port that owns the access
   always_ff @(posedge clk) begin
      if (reset) begin
         rvalid_p_r <= 1'b0;
         rvalid_d_r <= 1'b0;
         rdata_p_r  <= {DATA_W{1'b0}};
         rdata_d_r  <= {DATA_W{1'b0}};
      end else if ((estado_r == ACCESO) && leer_r) begin
         rvalid_p_r <= ~puerto_d_r;
         rvalid_d_r <= puerto_d_r;
         if (puerto_d_r) begin
            rdata_d_r <= Dataout;
         end else begin
            rdata_p_r <= Dataout;
         end
      end else begin
         rvalid_p_r <= 1'b0;
         rvalid_d_r <= 1'b0;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Last-granted record; starts at D so that P wins the first contention
   always_ff @(posedge clk) begin
      if (reset) begin
         ultimo_d_r <= 1'b1;
      end else if (gana_p_s) begin
         ultimo_d_r <= 1'b0;
      end else if (gana_d_s) begin
         ultimo_d_r <= 1'b1;
      end else begin
         ultimo_d_r <= ultimo_d_r;
      end
   end
`else
   // Anti-starvation counter: counts D's lost contentions, saturating at MAX_ESPERA
   always_ff @(posedge clk) begin
      if (reset) begin
         espera_r <= {EW{1'b0}};
      end else if (gana_d_s || !req_d) begin
         espera_r <= {EW{1'b0}};
      end else if (gana_p_s) begin
         if (espera_r != ESPERA_MAX) begin
            espera_r <= espera_r + {{(EW-1){1'b0}}, 1'b1};
         end else begin
            espera_r <= espera_r;
         end
      end else begin
         espera_r <= espera_r;
      end
   end
`endif

   assign gnt_p    = gana_p_s;
   assign gnt_d    = gana_d_s;
   assign rvalid_p = rvalid_p_r;
   assign rvalid_d = rvalid_d_r;
   assign rdata_p  = rdata_p_r;
   assign rdata_d  = rdata_d_r;
   assign EscrMem  = escr_r;
   assign LeerMem  = leer_r;
   assign Direc    = direc_r;
   assign Datain   = datain_r;
   assign ocupado  = (estado_r == ACCESO);

endmodule
